// File: rtl/fixed_to_posit_enc.sv
// Converts a signed Q8.8 fixed-point word into posit(16,1) with round-to-nearest-even.
// Multi-cycle: leading zeros are normalised out one bit per cycle, then packed in one cycle.
module fixed_to_posit_enc #(
   parameter int N    = 16,
   parameter int ES   = 1,
   parameter int FRAC = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      PACK = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [N-1:0]       mag_q, mag_d;
   logic signed [4:0]  scale_q, scale_d;
   logic               sign_q, sign_d;
   logic [N-1:0]       result_q, result_d;

   // pack datapath
   logic signed [4:0]  k;
   logic [4:0]         k_mag;
   logic [4:0]         reg_len;
   logic [31:0]        regime_field;
   logic [31:0]        combined;
   logic [31:0]        full;
   logic [15:0]        kept;
   logic [15:0]        rounded;
   logic               rnd_l, rnd_g, rnd_r, rnd_st, ulp;

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign out_data  = result_q;
   assign busy      = (state_q != IDLE);

   // Regime, exponent and fraction are assembled left-aligned just below the
   // zero sign bit of a 32-bit word; the low half holds the dropped bits.
   always_comb begin
      k            = scale_q >>> 1;
      k_mag        = 5'd0;
      reg_len      = 5'd0;
      regime_field = 32'd0;
      if (!k[4]) begin
         k_mag        = $unsigned(k);
         reg_len      = k_mag + 5'd2;
         regime_field = ((32'd1 << (k_mag + 5'd1)) - 32'd1) << 1;
      end else begin
         k_mag        = $unsigned(-k);
         reg_len      = k_mag + 5'd1;
         regime_field = 32'd1;
      end
      combined = (regime_field << 16) | {16'd0, scale_q[ES-1:0], mag_q[14:0]};
      full     = combined << (5'd15 - reg_len);
      kept     = full[31:16];
      rnd_l    = full[16];
      rnd_g    = full[15];
      rnd_r    = full[14];
      rnd_st   = |full[13:0];
      ulp      = (rnd_g & (rnd_r | rnd_st)) | (rnd_l & rnd_g & ~(rnd_r | rnd_st));
      // a carry out of the fraction ripples into e/regime naturally
      rounded  = kept + {15'd0, ulp};
   end

   always_comb begin
      state_d  = state_q;
      mag_d    = mag_q;
      scale_d  = scale_q;
      sign_d   = sign_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               sign_d  = in_data[N-1];
               mag_d   = in_data[N-1] ? (~in_data + 16'd1) : in_data;
               scale_d = 5'(N - 1 - FRAC);
               if (in_data == '0) begin
                  result_d = '0;
                  state_d  = DONE;
               end else begin
                  state_d  = NORM;
               end
            end
         end
         NORM: begin
            if (!mag_q[N-1]) begin
               mag_d   = mag_q << 1;
               scale_d = scale_q - 5'sd1;
            end else begin
               state_d = PACK;
            end
         end
         PACK: begin
            result_d = sign_q ? (~rounded + 16'd1) : rounded;
            state_d  = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mag_q    <= '0;
         scale_q  <= '0;
         sign_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         mag_q    <= mag_d;
         scale_q  <= scale_d;
         sign_q   <= sign_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_fixed_to_posit_enc.sv
// Bench for fixed_to_posit_enc: directed vectors, stall/reset scenarios and a
// randomized run scored against a bit-string posit reference model.
module tb_fixed_to_posit_enc;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        busy;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   fixed_to_posit_enc #(.N(16), .ES(1), .FRAC(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Value = m/256; posit bits are built as a plain list, then rounded RNE.
   function automatic logic [15:0] ref_posit(input logic [15:0] x);
      int m, p, sc, k, e;
      bit q[$];
      logic [15:0] r;
      bit lb, gb, rb, st, u;
      if (x == 16'h0000) return 16'h0000;
      m = x[15] ? (65536 - int'(x)) : int'(x);
      p = 15;
      while (((m >> p) & 1) == 0) p--;
      sc = p - 8;
      k  = (sc >= 0) ? sc / 2 : -((1 - sc) / 2);
      e  = sc - 2 * k;
      q.push_back(1'b0);
      if (k >= 0) begin
         repeat (k + 1) q.push_back(1'b1);
         q.push_back(1'b0);
      end else begin
         repeat (-k) q.push_back(1'b0);
         q.push_back(1'b1);
      end
      q.push_back(e != 0);
      for (int i = p - 1; i >= 0; i--) q.push_back(((m >> i) & 1) != 0);
      while (q.size() < 20) q.push_back(1'b0);
      r = 16'h0;
      for (int i = 0; i < 16; i++) r = {r[14:0], q[i]};
      lb = q[15]; gb = q[16]; rb = q[17]; st = 1'b0;
      for (int i = 18; i < q.size(); i++) st = st | q[i];
      u = (gb & (rb | st)) | (lb & gb & ~(rb | st));
      r = r + {15'd0, u};
      if (x[15]) r = 16'h0 - r;
      return r;
   endfunction

   function automatic int ref_lat(input logic [15:0] x);
      int m, p;
      if (x == 16'h0000) return 1;
      m = x[15] ? (65536 - int'(x)) : int'(x);
      p = 15;
      while (((m >> p) & 1) == 0) p--;
      return (15 - p) + 3;
   endfunction

   // Offers x, counts edges after the accept edge until out_valid is seen, then takes it.
   task automatic do_conv(input logic [15:0] x, input int hold, output logic [15:0] res,
                          output int lat, output bit acc);
      @(negedge clk);
      acc      = in_ready;
      in_valid = 1'b1;
      in_data  = x;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      res = out_data;
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; in_data = 16'h0100; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tot_cnt++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0000)
         $display("FAIL reset_state: ready=%b busy=%b valid=%b data=%h required 0 0 0 0000",
                  in_ready, busy, out_valid, out_data);
      else pass_cnt++;
      in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0;
      @(negedge clk);
      tot_cnt++;
      if (in_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL reset_release: ready=%b busy=%b required 1 0", in_ready, busy);
      else pass_cnt++;
   endtask

   task automatic test_directed;
      logic [15:0] vin [7] = '{16'h0100, 16'hFF00, 16'h0080, 16'h0001, 16'h7FFF, 16'h8000, 16'h0000};
      logic [15:0] vexp[7] = '{16'h4000, 16'hC000, 16'h3000, 16'h0400, 16'h7A00, 16'h8600, 16'h0000};
      int          vlat[7] = '{10, 10, 11, 18, 4, 3, 1};
      logic [15:0] res;
      int lat;
      bit acc;
      for (int i = 0; i < 7; i++) begin
         do_conv(vin[i], 0, res, lat, acc);
         tot_cnt++;
         if (res !== vexp[i] || lat != vlat[i] || !acc)
            $display("FAIL directed_%h: got %h lat %0d acc %b, required %h lat %0d acc 1",
                     vin[i], res, lat, acc, vexp[i], vlat[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_zero_hold;
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h0000;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h0100;
      for (int i = 0; i < 4; i++) begin
         tot_cnt++;
         if (out_valid !== 1'b1 || out_data !== 16'h0000 || busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL zero_hold_%0d: valid=%b data=%h busy=%b ready=%b required 1 0000 1 0",
                     i, out_valid, out_data, busy, in_ready);
         else pass_cnt++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_stall_bubble;
      int lat;
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h0100;
      @(posedge clk);
      @(negedge clk);
      in_data = 16'h0080;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      for (int i = 0; i < 5; i++) begin
         tot_cnt++;
         if (out_data !== 16'h4000 || in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL stall_%0d: data=%h ready=%b valid=%b required 4000 0 1",
                     i, out_data, in_ready, out_valid);
         else pass_cnt++;
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      tot_cnt++;
      if (busy !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL bubble: busy=%b ready=%b required 0 1", busy, in_ready);
      else pass_cnt++;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      tot_cnt++;
      if (out_data !== 16'h3000 || lat != 11)
         $display("FAIL after_bubble: got %h lat %0d required 3000 lat 11", out_data, lat);
      else pass_cnt++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [15:0] res;
      int lat;
      bit acc;
      bit seen;
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h0001;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tot_cnt++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0)
         $display("FAIL reset_mid: busy=%b valid=%b ready=%b required 0 0 0", busy, out_valid, in_ready);
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      tot_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_mid_ready: ready=%b required 1", in_ready);
      else pass_cnt++;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      tot_cnt++;
      if (seen !== 1'b0) $display("FAIL reset_mid_no_pulse: saw out_valid=%b required 0", seen);
      else pass_cnt++;
      do_conv(16'h0100, 0, res, lat, acc);
      tot_cnt++;
      if (res !== 16'h4000 || lat != 10)
         $display("FAIL reset_mid_recover: got %h lat %0d required 4000 lat 10", res, lat);
      else pass_cnt++;
   endtask

   task automatic test_random;
      logic [15:0] x, res, exp_r;
      int lat, exp_l;
      bit acc;
      for (int i = 0; i < 60; i++) begin
         case (i % 3)
            0: x = 16'($urandom);
            1: x = 16'($urandom_range(1, 255));
            default: x = 16'h0 - 16'($urandom_range(1, 4095));
         endcase
         exp_r = ref_posit(x);
         exp_l = ref_lat(x);
         do_conv(x, $urandom_range(0, 2), res, lat, acc);
         tot_cnt++;
         if (res !== exp_r || lat != exp_l || !acc || res === 16'h8000)
            $display("FAIL random_%h: got %h lat %0d acc %b, required %h lat %0d acc 1",
                     x, res, lat, acc, exp_r, exp_l);
         else pass_cnt++;
      end
   endtask

   initial begin
      in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0; rst = 1'b1;
      test_reset;
      test_directed;
      test_zero_hold;
      test_stall_bubble;
      test_reset_mid;
      test_random;
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/fixed_to_posit_enc.md
FIXED_TO_POSIT_ENC -- requirements
Module: fixed_to_posit_enc

Interface
REQ-001 SHALL have parameter N, default 16: posit and fixed-point word width; only 16 is supported.
REQ-002 SHALL have parameter ES, default 1: posit exponent field width; only 1 is supported.
REQ-003 SHALL have parameter FRAC, default 8: fraction bits of the fixed-point input (Q8.8).
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1: block can accept input.
REQ-008 SHALL have port in_data, input, 16: signed two's-complement Q8.8 value.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a result.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-011 SHALL have port out_data, output, 16: posit(16,1) encoding of the input.
REQ-012 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, NORM, PACK, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE with rst low; a transfer occurs when in_valid and in_ready are both high on a clock edge.
REQ-015 On transfer, the block SHALL register sign=in_data[15] and mag=|in_data| as 16-bit unsigned (0x8000 gives mag 0x8000), and SHALL set scale=7 as a signed 5-bit value.
REQ-016 On transfer with in_data=0x0000, the block SHALL load result 0x0000 and go directly to DONE.
REQ-017 On transfer with nonzero in_data, the block SHALL go to NORM.
REQ-018 NORM: each cycle, if mag[15]=0 the block SHALL set mag<=mag<<1 and scale<=scale-1 and stay in NORM; otherwise it SHALL go to PACK with no shift.
REQ-019 PACK (one cycle): k=floor(scale/2) (arithmetic shift), e=scale[0], hidden bit mag[15], fraction mag[14:0].
REQ-020 Regime encoding: k>=0 gives k+1 ones then a 0; k<0 gives -k zeros then a 1.
REQ-021 Unsigned pattern: {0, regime, e, fraction MSB-first}, truncated to 16 bits.
REQ-022 The result SHALL be rounded RNE at bit 0 of the unsigned pattern.
  - L = kept LSB; G = first dropped bit; R = next dropped bit; St = OR of the remaining dropped bits.
  - ulp = G&(R|St) | L&G&~(R|St), added to the unsigned pattern.
  - A rounding carry SHALL propagate into e/regime.
REQ-023 If sign=1, the result SHALL be the two's complement of the rounded pattern; the block SHALL then go to DONE.
REQ-024 Input range 2^-8..2^7 lies inside minpos..maxpos; no saturation path SHALL exist; the result SHALL never be 0x8000 (NaR).
REQ-025 DONE: out_valid=1 and out_data SHALL stay stable until out_ready=1; on the out_ready edge the block SHALL go to IDLE.
REQ-026 No input SHALL be accepted in the same cycle as the output handshake (one-cycle bubble).
REQ-027 Latency, with lz = leading zeros of mag:
  - nonzero input: out_valid rises lz+3 cycles after the accept edge; range 3..18.
  - zero input: out_valid rises 1 cycle after the accept edge.
REQ-028 in_valid, in_data and out_ready changes outside the handshake states SHALL have no effect.

Reset
REQ-029 With rst high at a clock edge, state SHALL become IDLE, out_valid 0, out_data 0x0000, busy 0, mag/scale/sign 0.
REQ-030 in_ready SHALL be 0 while rst is high.
REQ-031 Reset during NORM, PACK or DONE SHALL abandon the conversion; no out_valid pulse SHALL follow.
REQ-032 rst SHALL take priority over every handshake in the same cycle.

Verification
REQ-033 in_data=0x0100 (1.0) -> out_data=0x4000, out_valid 10 cycles after accept; in_data=0xFF00 -> 0xC000.
REQ-034 in_data=0x0080 (0.5) -> 0x3000; in_data=0x0001 (2^-8) -> 0x0400 at the maximum latency of 18.
REQ-035 in_data=0x7FFF -> unrounded 0x79FF rounds up to 0x7A00; in_data=0x8000 (-128) -> 0x8600 with latency 3.
REQ-036 in_data=0x0000 -> 0x0000 one cycle after accept; in_ready low and busy high until out_ready.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> out_data stable and in_ready=0 throughout; a second in_valid is not accepted until the cycle after the out handshake.
REQ-038 Assert rst mid-NORM for 0x0001 -> next cycle IDLE, out_valid 0, in_ready 1 after rst drops; a following 0x0100 still yields 0x4000.
